// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol width, clock-lane pattern and the control-period symbols.
package tmds_pkg;

   localparam int unsigned SYM_W = 10;

   localparam logic [SYM_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

   // Control-period symbols indexed by {vsync, hsync}
   localparam logic [SYM_W-1:0] CTRL_SYM_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL_SYM_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL_SYM_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL_SYM_11 = 10'b1010101011;

endpackage

// File: rtl/tmds_symbol_fifo.sv
// Small single-clock FIFO holding pre-encoded symbol sets; ready is registered "not full".
module tmds_symbol_fifo #(
   parameter int unsigned WIDTH = 30,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q;
   logic             do_push, do_pop;

   assign do_push = push && (cnt_q != CNT_W'(DEPTH));
   assign do_pop  = pop && (cnt_q != '0);
   assign empty   = (cnt_q == '0);
   assign ready   = ready_q;
   assign rdata   = mem[rd_q];

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ready_q <= (cnt_d != CNT_W'(DEPTH));
         if (do_push) begin
            wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: the count gates every read that matters.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_q] <= wdata;
      end
   end

endmodule

// File: rtl/tmds_serializer.sv
// TMDS lane serializer: buffers symbol sets and shifts them out LANE_BITS per clock.
// Define TMDS_SER_DIFF_EN to add registered complement outputs out_data_n / out_clk_n.
module tmds_serializer
   import tmds_pkg::*;
#(
   parameter int unsigned       NUM_CH      = 3,
   parameter int unsigned       LANE_BITS   = 1,
   parameter int unsigned       FIFO_DEPTH  = 2,
   parameter logic [SYM_W-1:0]  IDLE_SYMBOL = CTRL_SYM_00
) (
   input  logic                          tmds_clk,
   input  logic                          reset_n,
   input  logic [SYM_W*NUM_CH-1:0]       in_sym,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          clr_underflow,
   output logic [LANE_BITS*NUM_CH-1:0]   out_data,
   output logic [LANE_BITS-1:0]          out_clk,
`ifdef TMDS_SER_DIFF_EN
   output logic [LANE_BITS*NUM_CH-1:0]   out_data_n,
   output logic [LANE_BITS-1:0]          out_clk_n,
`endif
   output logic                          sym_strobe,
   output logic                          underflow_pulse,
   output logic                          underflow_flag
);

   localparam int unsigned RATIO = SYM_W / LANE_BITS;
   localparam int unsigned PH_W  = $clog2(RATIO);

   logic [PH_W-1:0]           phase_q;
   logic [SYM_W*NUM_CH-1:0]   sh_q, sh_d, head;
   logic [SYM_W-1:0]          ck_q, ck_d;
   logic                      load, push, pop, fifo_empty;
   logic                      strobe_q, uf_pulse_q, uf_flag_q;

   assign load = (phase_q == PH_W'(RATIO - 1));
   assign push = in_valid && in_ready;
   // Emptiness is sampled before this edge's push, so a same-edge push waits a symbol.
   assign pop  = load && !fifo_empty;

   tmds_symbol_fifo #(
      .WIDTH (SYM_W * NUM_CH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (tmds_clk),
      .rst_n (reset_n),
      .push  (push),
      .wdata (in_sym),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .ready (in_ready)
   );

   always_comb begin
      sh_d = sh_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (load) begin
            sh_d[k*SYM_W +: SYM_W] = pop ? head[k*SYM_W +: SYM_W] : IDLE_SYMBOL;
         end else begin
            sh_d[k*SYM_W +: SYM_W] = sh_q[k*SYM_W +: SYM_W] >> LANE_BITS;
         end
      end
      ck_d = load ? TMDS_CLK_PATTERN : (ck_q >> LANE_BITS);
   end

   always_ff @(posedge tmds_clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q    <= '0;
         sh_q       <= '0;
         ck_q       <= '0;
         strobe_q   <= 1'b0;
         uf_pulse_q <= 1'b0;
         uf_flag_q  <= 1'b0;
      end else begin
         phase_q    <= load ? '0 : phase_q + 1'b1;
         sh_q       <= sh_d;
         ck_q       <= ck_d;
         strobe_q   <= load;
         uf_pulse_q <= load && fifo_empty;
         // A fresh underflow wins over a simultaneous clear.
         if (load && fifo_empty) begin
            uf_flag_q <= 1'b1;
         end else if (clr_underflow) begin
            uf_flag_q <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane_out
      assign out_data[k*LANE_BITS +: LANE_BITS] = sh_q[k*SYM_W +: LANE_BITS];
   end
   assign out_clk         = ck_q[LANE_BITS-1:0];
   assign sym_strobe      = strobe_q;
   assign underflow_pulse = uf_pulse_q;
   assign underflow_flag  = uf_flag_q;

`ifdef TMDS_SER_DIFF_EN
   logic [LANE_BITS*NUM_CH-1:0] data_n_q, data_next;
   logic [LANE_BITS-1:0]        clk_n_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane_next
      assign data_next[k*LANE_BITS +: LANE_BITS] = sh_d[k*SYM_W +: LANE_BITS];
   end

   always_ff @(posedge tmds_clk or negedge reset_n) begin
      if (!reset_n) begin
         data_n_q <= '1;
         clk_n_q  <= '1;
      end else begin
         data_n_q <= ~data_next;
         clk_n_q  <= ~ck_d[LANE_BITS-1:0];
      end
   end

   assign out_data_n = data_n_q;
   assign out_clk_n  = clk_n_q;
`endif

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench: 1-bit/lane instance for data path checks, 2-bit/lane instance left idle.
module tb_tmds_serializer;

   typedef struct {
      logic        valid;
      logic [29:0] sym;
      logic [2:0]  data;
      logic        clk;
      logic        strobe;
      logic        upulse;
      logic        flag;
   } vec_t;

   localparam logic [29:0] S_JUNK = {10'h2AA, 10'h2AA, 10'h2AA};
   localparam logic [29:0] S_MAIN = {10'h155, 10'h000, 10'h3FF};
   localparam logic [29:0] S_A    = {10'h0F1, 10'h2C3, 10'h11E};
   localparam logic [29:0] S_B    = {10'h3A5, 10'h05A, 10'h1E1};
   localparam logic [29:0] S_C    = {10'h24B, 10'h0D2, 10'h36C};
   localparam logic [29:0] S_D    = {10'h3FF, 10'h3FF, 10'h3FF};

   logic        tmds_clk = 1'b0;
   logic        reset_n, in_valid, clr_underflow;
   logic [29:0] in_sym;
   logic        in_ready, out_clk, sym_strobe, underflow_pulse, underflow_flag;
   logic [2:0]  out_data;
   logic        in_ready2, sym_strobe2, underflow_pulse2, underflow_flag2;
   logic [5:0]  out_data2;
   logic [1:0]  out_clk2;
`ifdef TMDS_SER_DIFF_EN
   logic [2:0]  out_data_n;
   logic        out_clk_n;
   logic [5:0]  out_data_n2;
   logic [1:0]  out_clk_n2;
`endif

   int checks   = 0;
   int failures = 0;

   logic [1:0] idle_sl [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
   logic [1:0] clk_sl  [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

   always #5 tmds_clk = ~tmds_clk;

   tmds_serializer #(
      .NUM_CH     (3),
      .LANE_BITS  (1),
      .FIFO_DEPTH (2)
   ) u_dut (
      .tmds_clk        (tmds_clk),
      .reset_n         (reset_n),
      .in_sym          (in_sym),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .clr_underflow   (clr_underflow),
      .out_data        (out_data),
      .out_clk         (out_clk),
`ifdef TMDS_SER_DIFF_EN
      .out_data_n      (out_data_n),
      .out_clk_n       (out_clk_n),
`endif
      .sym_strobe      (sym_strobe),
      .underflow_pulse (underflow_pulse),
      .underflow_flag  (underflow_flag)
   );

   tmds_serializer #(
      .NUM_CH     (3),
      .LANE_BITS  (2),
      .FIFO_DEPTH (2)
   ) u_dut2 (
      .tmds_clk        (tmds_clk),
      .reset_n         (reset_n),
      .in_sym          (30'd0),
      .in_valid        (1'b0),
      .in_ready        (in_ready2),
      .clr_underflow   (1'b0),
      .out_data        (out_data2),
      .out_clk         (out_clk2),
`ifdef TMDS_SER_DIFF_EN
      .out_data_n      (out_data_n2),
      .out_clk_n       (out_clk_n2),
`endif
      .sym_strobe      (sym_strobe2),
      .underflow_pulse (underflow_pulse2),
      .underflow_flag  (underflow_flag2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge tmds_clk);
      @(negedge tmds_clk);
   endtask

   // Gathers ten serial bits per lane, starting just after a load edge.
   task automatic collect(output logic [29:0] got);
      got = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         if (i == 1) in_valid = 1'b0;
         for (int k = 0; k < 3; k++) got[k*10+i] = out_data[k];
      end
   endtask

`ifdef TMDS_SER_DIFF_EN
   always @(negedge tmds_clk) begin
      check("diff data", 32'(out_data_n), 32'(~out_data));
      check("diff clk", 32'(out_clk_n), 32'(~out_clk));
      check("diff data2", 32'(out_data_n2), 32'(~out_data2));
      check("diff clk2", 32'(out_clk_n2), 32'(~out_clk2));
   end
`endif

   initial begin
      vec_t        tbl [1:20];
      logic [29:0] got;
      int          ph;

      reset_n = 1'b0;
      in_valid = 1'b0;
      in_sym = '0;
      clr_underflow = 1'b0;

      for (int r = 1; r <= 20; r++) begin
         tbl[r].valid = 1'b0;
         tbl[r].sym = '0;
         tbl[r].data = 3'b000;
         tbl[r].clk = 1'b0;
         tbl[r].strobe = 1'b0;
         tbl[r].upulse = 1'b0;
         tbl[r].flag = (r >= 20);
      end
      tbl[1].valid = 1'b1;  tbl[1].sym = S_JUNK;   // offered while in_ready is still low
      tbl[2].valid = 1'b1;  tbl[2].sym = S_MAIN;
      for (int r = 10; r <= 19; r++) begin
         tbl[r].data = {((r - 10) % 2 == 0), 1'b0, 1'b1};
         tbl[r].clk = (r < 15);
      end
      tbl[10].strobe = 1'b1;
      tbl[20].strobe = 1'b1;
      tbl[20].clk = 1'b1;
      tbl[20].upulse = 1'b1;

      @(negedge tmds_clk);
      check("rst data", 32'(out_data), 32'd0);
      check("rst clk", 32'(out_clk), 32'd0);
      check("rst ready", 32'(in_ready), 32'd0);
      check("rst strobe", 32'(sym_strobe), 32'd0);
      check("rst upulse", 32'(underflow_pulse), 32'd0);
      check("rst flag", 32'(underflow_flag), 32'd0);
      check("rst data2", 32'(out_data2), 32'd0);
`ifdef TMDS_SER_DIFF_EN
      check("rst data_n", 32'(out_data_n), 32'h7);
      check("rst clk_n", 32'(out_clk_n), 32'h1);
`endif
      @(negedge tmds_clk);
      reset_n = 1'b1;

      for (int r = 1; r <= 20; r++) begin
         in_valid = tbl[r].valid;
         in_sym = tbl[r].sym;
         tick();
         check($sformatf("row%0d data", r), 32'(out_data), 32'(tbl[r].data));
         check($sformatf("row%0d clk", r), 32'(out_clk), 32'(tbl[r].clk));
         check($sformatf("row%0d strobe", r), 32'(sym_strobe), 32'(tbl[r].strobe));
         check($sformatf("row%0d upulse", r), 32'(underflow_pulse), 32'(tbl[r].upulse));
         check($sformatf("row%0d flag", r), 32'(underflow_flag), 32'(tbl[r].flag));
         check($sformatf("row%0d ready", r), 32'(in_ready), 32'd1);
         ph = (r - 5) % 5;
         check($sformatf("row%0d data2", r), 32'(out_data2),
               (r < 5) ? 32'd0 : 32'({3{idle_sl[ph]}}));
         check($sformatf("row%0d clk2", r), 32'(out_clk2),
               (r < 5) ? 32'd0 : 32'(clk_sl[ph]));
         check($sformatf("row%0d upulse2", r), 32'(underflow_pulse2),
               32'((r >= 5) && (r % 5 == 0)));
         check($sformatf("row%0d flag2", r), 32'(underflow_flag2), 32'(r >= 5));
      end
      in_valid = 1'b0;

      // Clear on an ordinary cycle, then collide a clear with an underflow load.
      clr_underflow = 1'b1;
      tick();
      check("clr flag", 32'(underflow_flag), 32'd0);
      clr_underflow = 1'b0;
      repeat (8) tick();
      check("flag held clear", 32'(underflow_flag), 32'd0);
      clr_underflow = 1'b1;
      tick();
      check("clr vs underflow flag", 32'(underflow_flag), 32'd1);
      check("clr vs underflow pulse", 32'(underflow_pulse), 32'd1);
      clr_underflow = 1'b0;

      // Fill the two-entry buffer, hold the third set until a pop frees space.
      in_valid = 1'b1;
      in_sym = S_A;
      tick();
      check("ready after 1 push", 32'(in_ready), 32'd1);
      in_sym = S_B;
      tick();
      check("ready full", 32'(in_ready), 32'd0);
      in_sym = S_C;
      repeat (7) tick();
      check("ready still full", 32'(in_ready), 32'd0);
      tick();
      check("ready after pop", 32'(in_ready), 32'd1);
      check("strobe at pop", 32'(sym_strobe), 32'd1);
      check("no underflow at pop", 32'(underflow_pulse), 32'd0);
      collect(got);
      check("order A", 32'(got), 32'(S_A));
      tick();
      collect(got);
      check("order B", 32'(got), 32'(S_B));
      tick();
      collect(got);
      check("order C", 32'(got), 32'(S_C));

      // Buffer a set, then reset at phase 4; it must be discarded.
      tick();
      in_valid = 1'b1;
      in_sym = S_D;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      check("midrst data", 32'(out_data), 32'd0);
      check("midrst clk", 32'(out_clk), 32'd0);
      check("midrst ready", 32'(in_ready), 32'd0);
      check("midrst strobe", 32'(sym_strobe), 32'd0);
      check("midrst flag", 32'(underflow_flag), 32'd0);
`ifdef TMDS_SER_DIFF_EN
      check("midrst data_n", 32'(out_data_n), 32'h7);
`endif
      @(negedge tmds_clk);
      reset_n = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         tick();
         if (r == 1) check("post rst ready", 32'(in_ready), 32'd1);
         if (r == 9) begin
            check("post rst no early load", 32'(sym_strobe), 32'd0);
            check("post rst clk idle", 32'(out_clk), 32'd0);
         end
         if (r == 10) begin
            check("post rst load strobe", 32'(sym_strobe), 32'd1);
            check("post rst underflow", 32'(underflow_pulse), 32'd1);
            check("post rst discarded", 32'(out_data), 32'd0);
            check("post rst clk", 32'(out_clk), 32'd1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
